float32_mac_serializer: RTL

FLOAT32_MAC_SERIALIZER -- requirements
Module: float32_mac_serializer

---
 rtl/float32_mac_pkg.sv | 29 ++
 rtl/float32_vec_fifo.sv | 52 +++++
 rtl/float32_mac_serializer.sv | 117 +++++++++++
 3 files changed

// File: rtl/float32_mac_pkg.sv
// Shared constants, FSM state type and FIFO entry layout for the float32 MAC result serializer.
package float32_mac_pkg;

  localparam int unsigned LANES      = 16;
  localparam int unsigned LANE_W     = 32;
  localparam int unsigned LANE_IDX_W = 4;
  localparam int unsigned ENTRY_W    = LANES * LANE_W + LANES + 2 + 1;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  typedef struct packed {
    logic                    exc;
    logic [1:0]              ovf;
    logic [LANES-1:0]        mask;
    logic [LANES*LANE_W-1:0] data;
  } entry_t;

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic logic [LANE_IDX_W-1:0] first_lane(input logic [LANES-1:0] mask);
    first_lane = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask[i]) first_lane = LANE_IDX_W'(i);
    end
  endfunction

endpackage

// File: rtl/float32_vec_fifo.sv
// Power-of-two vector FIFO with first-word-fall-through read port and occupancy count.
module float32_vec_fifo
  import float32_mac_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = ENTRY_W
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == CntW'(DEPTH));
  assign count_o = r_count;
  assign rdata_o = r_mem[r_rptr];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && (r_count != '0);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PtrW'(1);
      if (w_pop)  r_rptr <= r_rptr + PtrW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CntW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= wdata_i;
  end

endmodule

// File: rtl/float32_mac_serializer.sv
// Buffers 16-lane float32 MAC result vectors and emits the enabled lanes one word per handshake.
module float32_mac_serializer
  import float32_mac_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [LANES*LANE_W-1:0]    floatq_i,
  input  logic [LANES-1:0]           lane_mask_i,
  input  logic [1:0]                 overflow_i,
  input  logic                       exception_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [LANE_W-1:0]          out_data_o,
  output logic [LANE_IDX_W-1:0]      out_lane_o,
  output logic                       out_last_o,
  output logic [1:0]                 sticky_ovf_o,
  output logic                       sticky_exc_o,
  input  logic                       clear_sticky_i,
  output logic [$clog2(DEPTH):0]     occupancy_o
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  state_e                        r_state;
  state_e                        w_state_next;
  logic [LANE_IDX_W-1:0]         r_lane;
  logic [LANE_IDX_W-1:0]         w_lane_next;
  logic [1:0]                    r_sticky_ovf;
  logic [1:0]                    w_sticky_ovf_next;
  logic                          r_sticky_exc;
  logic                          w_sticky_exc_next;

  entry_t                        w_in_entry;
  entry_t                        w_head;
  logic [LANES-1:0][LANE_W-1:0]  w_lanes;
  logic [LANES-1:0]              w_remaining;
  logic [LANES-1:0]              w_after;
  logic [LANE_IDX_W-1:0]         w_cur;
  logic [CntW-1:0]               w_count;
  logic                          w_full;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_fire;
  logic                          w_last;
  logic                          w_unused_head_flags;

  assign w_in_entry = '{exc: exception_i, ovf: overflow_i, mask: lane_mask_i, data: floatq_i};
  assign in_ready_o = !rst_i && !w_full;
  assign w_push     = in_valid_i && in_ready_o;

  float32_vec_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (w_in_entry),
    .rdata_o (w_head),
    .count_o (w_count),
    .full_o  (w_full)
  );

  // Flags are folded into the stickies at acceptance; the stored copies are not read back.
  assign w_unused_head_flags = ^{w_head.exc, w_head.ovf};

  assign w_lanes     = w_head.data;
  assign w_remaining = w_head.mask & ({LANES{1'b1}} << r_lane);
  assign w_cur       = first_lane(w_remaining);
  assign w_after     = w_remaining & ~(LANES'(1) << w_cur);
  assign w_last      = (w_after == '0);

  assign out_valid_o  = !rst_i && (r_state == StSend) && (w_remaining != '0);
  assign out_data_o   = w_lanes[w_cur];
  assign out_lane_o   = w_cur;
  assign out_last_o   = w_last;
  assign w_fire       = out_valid_o && out_ready_i;
  // An all-masked head has nothing to emit and is dropped without a handshake.
  assign w_pop        = (r_state == StSend) && ((w_fire && w_last) || (w_remaining == '0));
  assign occupancy_o  = w_count;
  assign sticky_ovf_o = r_sticky_ovf;
  assign sticky_exc_o = r_sticky_exc;

  always_comb begin
    w_state_next      = r_state;
    w_lane_next       = r_lane;
    w_sticky_ovf_next = (clear_sticky_i ? 2'b00 : r_sticky_ovf) | (w_push ? overflow_i : 2'b00);
    w_sticky_exc_next = (clear_sticky_i ? 1'b0 : r_sticky_exc) | (w_push && exception_i);
    unique case (r_state)
      StIdle: if (w_push) w_state_next = StSend;
      StSend: if (w_pop && !w_push && (w_count == CntW'(1))) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
    if (w_pop)       w_lane_next = '0;
    else if (w_fire) w_lane_next = w_cur + LANE_IDX_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= StIdle;
      r_lane       <= '0;
      r_sticky_ovf <= '0;
      r_sticky_exc <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_lane       <= w_lane_next;
      r_sticky_ovf <= w_sticky_ovf_next;
      r_sticky_exc <= w_sticky_exc_next;
    end
  end

endmodule
